// File: rtl/clock_pkg.sv
// Shared constants, button-repeat state encoding and a wrap helper
// for the time-of-day counters.
package clock_pkg;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } btn_state_t;

    // Using >= keeps a field inside its legal range even if it was ever corrupted.
    function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max_value);
        return (value >= max_value) ? 8'd0 : value + 8'd1;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Per-button rising-edge detect with hold-to-repeat. It produces a one-cycle
// increment request that the time counters consume on the same edge.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic btn,
    output logic inc_pulse
);

    localparam int DELAY_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int RATE_W  = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam int CNT_W   = (DELAY_W > RATE_W) ? DELAY_W : RATE_W;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    btn_state_t       state;
    btn_state_t       next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             btn_prev;

    // btn_prev resets high so a button still held through reset is not a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            btn_prev <= 1'b1;
        end else begin
            state    <= next_state;
            count    <= next_count;
            btn_prev <= btn;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        inc_pulse  = 1'b0;
        if (!enable) begin
            next_state = IDLE;
            next_count = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn && !btn_prev) begin
                        inc_pulse  = 1'b1;
                        next_state = DELAY;
                        next_count = '0;
                    end
                end
                DELAY: begin
                    if (!btn) begin
                        next_state = IDLE;
                        next_count = '0;
                    end else if (count == DELAY_LAST) begin
                        inc_pulse  = 1'b1;
                        next_state = REPEAT;
                        next_count = '0;
                    end else begin
                        next_count = count + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!btn) begin
                        next_state = IDLE;
                        next_count = '0;
                    end else if (count == RATE_LAST) begin
                        inc_pulse  = 1'b1;
                        next_count = '0;
                    end else begin
                        next_count = count + 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_count = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour time-of-day keeper: a 1 Hz prescaler drives the second/minute/hour
// counters, and a set mode lets the front-panel buttons adjust hours and minutes.
module time_keeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV     = 50000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       btn_hour,
    input  logic       btn_minute,
    output logic [7:0] current_hour,
    output logic [7:0] current_minute,
    output logic [7:0] current_second,
    output logic       second_tick
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescaler;
    logic             tick_now;
    logic             hour_inc;
    logic             minute_inc;

    assign tick_now = !set_mode && (prescaler == TICK_LAST);

    btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_hour_btn (
        .clk      (clk),
        .rst      (rst),
        .enable   (set_mode),
        .btn      (btn_hour),
        .inc_pulse(hour_inc)
    );

    btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_minute_btn (
        .clk      (clk),
        .rst      (rst),
        .enable   (set_mode),
        .btn      (btn_minute),
        .inc_pulse(minute_inc)
    );

    // Holding the prescaler at zero in set mode makes the first tick after
    // leaving set mode land a full TICK_DIV cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            second_tick <= 1'b0;
        end else if (set_mode) begin
            prescaler   <= '0;
            second_tick <= 1'b0;
        end else if (tick_now) begin
            prescaler   <= '0;
            second_tick <= 1'b1;
        end else begin
            prescaler   <= prescaler + 1'b1;
            second_tick <= 1'b0;
        end
    end

    // Button increments never carry; only the running tick ripples upward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_hour   <= 8'd0;
            current_minute <= 8'd0;
            current_second <= 8'd0;
        end else if (set_mode) begin
            current_second <= 8'd0;
            if (hour_inc) begin
                current_hour <= wrap_inc(current_hour, HOUR_MAX);
            end
            if (minute_inc) begin
                current_minute <= wrap_inc(current_minute, MIN_MAX);
            end
        end else if (tick_now) begin
            current_second <= wrap_inc(current_second, SEC_MAX);
            if (current_second >= SEC_MAX) begin
                current_minute <= wrap_inc(current_minute, MIN_MAX);
                if (current_minute >= MIN_MAX) begin
                    current_hour <= wrap_inc(current_hour, HOUR_MAX);
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Randomised and directed bench for time_keeper, checked against a
// seconds-of-day reference model driven by hold-duration arithmetic.
module tb_time_keeper;

    localparam int TICK_DIV     = 4;
    localparam int REPEAT_DELAY = 6;
    localparam int REPEAT_RATE  = 3;
    localparam int DAY_SECONDS  = 86400;

    logic       clk;
    logic       rst;
    logic       set_mode;
    logic       btn_hour;
    logic       btn_minute;
    logic [7:0] current_hour;
    logic [7:0] current_minute;
    logic [7:0] current_second;
    logic       second_tick;

    int checks_total;
    int checks_passed;

    // Reference model state: time as seconds-of-day, plus per-button hold tracking.
    int tod;
    int run_cycles;
    int exp_tick;
    bit prev_b [2];
    bit armed  [2];
    int held   [2];

    time_keeper #(
        .TICK_DIV    (TICK_DIV),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .set_mode      (set_mode),
        .btn_hour      (btn_hour),
        .btn_minute    (btn_minute),
        .current_hour  (current_hour),
        .current_minute(current_minute),
        .current_second(current_second),
        .second_tick   (second_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void resetModel();
        tod        = 0;
        run_cycles = 0;
        exp_tick   = 0;
        for (int i = 0; i < 2; i++) begin
            prev_b[i] = 1'b1;
            armed[i]  = 1'b0;
            held[i]   = 0;
        end
    endfunction

    // An increment fires on the press edge, then REPEAT_DELAY edges later,
    // then every REPEAT_RATE edges for as long as the press stays held.
    function automatic bit modelButton(input int idx, input bit v, input bit sm);
        bit inc;
        inc = 1'b0;
        if (!sm) begin
            armed[idx] = 1'b0;
        end else if (armed[idx]) begin
            if (v) begin
                held[idx]++;
                if (held[idx] >= REPEAT_DELAY && ((held[idx] - REPEAT_DELAY) % REPEAT_RATE) == 0)
                    inc = 1'b1;
            end else begin
                armed[idx] = 1'b0;
            end
        end else if (v && !prev_b[idx]) begin
            armed[idx] = 1'b1;
            held[idx]  = 0;
            inc        = 1'b1;
        end
        prev_b[idx] = v;
        return inc;
    endfunction

    function automatic void modelEdge(input bit sm, input bit bh, input bit bm);
        bit h_inc;
        bit m_inc;
        int h;
        int m;
        h_inc = modelButton(0, bh, sm);
        m_inc = modelButton(1, bm, sm);
        if (sm) begin
            run_cycles = 0;
            exp_tick   = 0;
            h = tod / 3600;
            m = (tod / 60) % 60;
            if (h_inc) h = (h + 1) % 24;
            if (m_inc) m = (m + 1) % 60;
            tod = h * 3600 + m * 60;
        end else begin
            run_cycles++;
            exp_tick = ((run_cycles % TICK_DIV) == 0) ? 1 : 0;
            if (exp_tick == 1) tod = (tod + 1) % DAY_SECONDS;
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "_hour"},   int'(current_hour),   tod / 3600);
        checkOutput({tag, "_minute"}, int'(current_minute), (tod / 60) % 60);
        checkOutput({tag, "_second"}, int'(current_second), tod % 60);
        checkOutput({tag, "_tick"},   int'(second_tick),    exp_tick);
    endtask

    // Called just after a rising edge: drive, take one edge, then compare.
    task automatic applyStimulus(input bit sm, input bit bh, input bit bm, input string tag);
        set_mode   = sm;
        btn_hour   = bh;
        btn_minute = bm;
        @(posedge clk);
        modelEdge(sm, bh, bm);
        #1;
        checkAll(tag);
    endtask

    // Reset is raised between edges and must clear the outputs before any edge.
    task automatic asyncReset(input int cycles);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_hour",   int'(current_hour),   0);
        checkOutput("async_rst_minute", int'(current_minute), 0);
        checkOutput("async_rst_second", int'(current_second), 0);
        checkOutput("async_rst_tick",   int'(second_tick),    0);
        resetModel();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulseButton(input bit hour_btn, input int count, input string tag);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, hour_btn, !hour_btn, tag);
            applyStimulus(1'b1, 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        bit sm;
        bit bh;
        bit bm;
        int steps;
        checks_total  = 0;
        checks_passed = 0;
        rst        = 1'b1;
        set_mode   = 1'b0;
        btn_hour   = 1'b0;
        btn_minute = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkAll("reset");

        // Reset in the middle of a count, then watch the tick cadence.
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, "precount");
        asyncReset(3);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, "tick_cadence");
        checkOutput("tick_second_after_two", int'(current_second), 2);

        // Auto-repeat from hour 0.
        asyncReset(2);
        applyStimulus(1'b1, 1'b0, 1'b0, "enter_set");
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, "repeat_hold");
        checkOutput("repeat_final_hour", int'(current_hour), 4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, "repeat_release");
        checkOutput("repeat_release_hour", int'(current_hour), 4);

        // Single minute press at 05:59 wraps the minute without touching hour.
        pulseButton(1'b1, 1, "to_hour5");
        pulseButton(1'b0, 59, "to_min59");
        pulseButton(1'b0, 1, "min_wrap");
        checkOutput("min_wrap_hour",   int'(current_hour),   5);
        checkOutput("min_wrap_minute", int'(current_minute), 0);
        checkOutput("min_wrap_second", int'(current_second), 0);

        // Full-day rollover from 23:59:59.
        pulseButton(1'b1, 18, "to_hour23");
        pulseButton(1'b0, 59, "to_min59b");
        for (int i = 0; i < 59 * TICK_DIV; i++) applyStimulus(1'b0, 1'b0, 1'b0, "run_to_end");
        checkOutput("end_of_day_hour",   int'(current_hour),   23);
        checkOutput("end_of_day_minute", int'(current_minute), 59);
        checkOutput("end_of_day_second", int'(current_second), 59);
        for (int i = 0; i < TICK_DIV; i++) applyStimulus(1'b0, 1'b0, 1'b0, "rollover");
        checkOutput("rollover_hour", int'(current_hour), 0);
        checkOutput("rollover_tick", int'(second_tick),  1);

        // Buttons in run mode are ignored; entering set mode clears seconds.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, "run_btn");
        applyStimulus(1'b0, 1'b0, 1'b0, "run_btn_release");
        steps = 0;
        while ((tod % 60) != 37 && steps < 400) begin
            applyStimulus(1'b0, 1'b0, 1'b0, "run_to_37");
            steps++;
        end
        checkOutput("reach_37", int'(current_second), 37);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, "set_clears_sec");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, "min_held");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, "drop_set_held");
        applyStimulus(1'b1, 1'b0, 1'b1, "reenter_held");
        applyStimulus(1'b1, 1'b0, 1'b0, "min_release");

        // Reset while repeating: the still-held button must stay inert.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, "into_repeat");
        btn_hour = 1'b1;
        asyncReset(2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, "held_after_rst");
        checkOutput("held_after_rst_final", int'(current_hour), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, "rst_release");
        applyStimulus(1'b1, 1'b1, 1'b0, "rst_repress");
        checkOutput("repress_hour", int'(current_hour), 1);

        // Randomised phase with persistent levels and occasional resets.
        sm = 1'b0;
        bh = 1'b0;
        bm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) sm = ~sm;
            if ($urandom_range(7) == 0)  bh = ~bh;
            if ($urandom_range(9) == 0)  bm = ~bm;
            if ($urandom_range(299) == 0) begin
                btn_hour   = bh;
                btn_minute = bm;
                set_mode   = sm;
                asyncReset(int'($urandom_range(1, 3)));
            end else begin
                applyStimulus(sm, bh, bm, "random");
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
